// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide on operand
// magnitudes, one radix-2 step per cycle, with single-cycle handling of the RISC-V special cases.
module ex_muldiv_unit #(
   parameter int XLEN = 32,
   parameter int RDW  = 5
) (
   input  logic            clkIn,
   input  logic            resetIn,
   input  logic            startIn,
   input  logic [2:0]      funct3In,
   input  logic [XLEN-1:0] rs1DataIn,
   input  logic [XLEN-1:0] rs2DataIn,
   input  logic [RDW-1:0]  rdIn,
   input  logic            flushIn,
   output logic            busyOut,
   output logic            stallOut,
   output logic            doneOut,
   output logic [XLEN-1:0] resultOut,
   output logic [RDW-1:0]  rdOut
);

   localparam int CW = $clog2(XLEN + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [2:0]        op_q, op_d;
   logic [RDW-1:0]    rd_q, rd_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [2*XLEN-1:0] prod_q, prod_d;
   logic [XLEN-1:0]   opnd_q, opnd_d;
   logic              neg_q, neg_d;
   logic [XLEN-1:0]   result_q, result_d;
   logic [RDW-1:0]    rd_out_q, rd_out_d;

   // Operand decode at issue: which operands are signed, their magnitudes, and the final sign.
   logic            is_div_in, a_signed_in, b_signed_in, sa_in, sb_in, neg_in;
   logic [XLEN-1:0] ma_in, mb_in;
   logic            div_zero_in, div_ovf_in, special_in;
   logic [XLEN-1:0] special_res_in;

   assign is_div_in   = funct3In[2];
   assign a_signed_in = is_div_in ? ~funct3In[0] : (funct3In != 3'd3);
   assign b_signed_in = is_div_in ? ~funct3In[0] : ~funct3In[1];
   assign sa_in       = a_signed_in & rs1DataIn[XLEN-1];
   assign sb_in       = b_signed_in & rs2DataIn[XLEN-1];
   assign ma_in       = sa_in ? -rs1DataIn : rs1DataIn;
   assign mb_in       = sb_in ? -rs2DataIn : rs2DataIn;
   assign neg_in      = (is_div_in & funct3In[1]) ? sa_in : (sa_in ^ sb_in);

   assign div_zero_in = is_div_in & (rs2DataIn == '0);
   assign div_ovf_in  = is_div_in & ~funct3In[0] & (rs1DataIn == {1'b1, {(XLEN-1){1'b0}}})
                        & (rs2DataIn == '1);
   assign special_in  = div_zero_in | div_ovf_in;
   always_comb begin
      if (div_zero_in) special_res_in = funct3In[1] ? rs1DataIn : '1;
      else             special_res_in = funct3In[1] ? '0 : rs1DataIn;
   end

   // One iteration step. Multiply: add multiplicand into the high half, shift right.
   // Divide: shift remainder:dividend left, subtract divisor when it fits, shift in quotient bit.
   logic [XLEN:0]     mul_sum, div_shift;
   logic [XLEN-1:0]   div_diff;
   logic              div_ge;
   logic [2*XLEN-1:0] mul_next, div_next, step_prod, mul_fix;
   logic [XLEN-1:0]   div_sel, final_res;

   assign mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
   assign mul_next  = {mul_sum, prod_q[XLEN-1:1]};
   assign div_shift = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1]};
   assign div_ge    = div_shift >= {1'b0, opnd_q};
   assign div_diff  = div_shift[XLEN-1:0] - opnd_q;
   assign div_next  = {(div_ge ? div_diff : div_shift[XLEN-1:0]), prod_q[XLEN-2:0], div_ge};
   assign step_prod = op_q[2] ? div_next : mul_next;

   assign mul_fix   = neg_q ? -step_prod : step_prod;
   assign div_sel   = op_q[1] ? step_prod[2*XLEN-1:XLEN] : step_prod[XLEN-1:0];
   always_comb begin
      if (op_q[2])            final_res = neg_q ? -div_sel : div_sel;
      else if (op_q == 3'd0)  final_res = mul_fix[XLEN-1:0];
      else                    final_res = mul_fix[2*XLEN-1:XLEN];
   end

   always_comb begin
      // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latches).
      state_d  = state_q;
      op_d     = op_q;
      rd_d     = rd_q;
      cnt_d    = cnt_q;
      prod_d   = prod_q;
      opnd_d   = opnd_q;
      neg_d    = neg_q;
      result_d = result_q;
      rd_out_d = rd_out_q;

      if (flushIn) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            CALC: begin
               prod_d = step_prod;
               cnt_d  = cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  state_d  = DONE;
                  result_d = final_res;
                  rd_out_d = rd_q;
               end
            end
            default: begin
               state_d = IDLE;
               if (startIn) begin
                  op_d  = funct3In;
                  rd_d  = rdIn;
                  neg_d = neg_in;
                  if (special_in) begin
                     state_d  = DONE;
                     result_d = special_res_in;
                     rd_out_d = rdIn;
                  end else begin
                     state_d = CALC;
                     cnt_d   = CW'(XLEN);
                     prod_d  = {{XLEN{1'b0}}, (is_div_in ? ma_in : mb_in)};
                     opnd_d  = is_div_in ? mb_in : ma_in;
                  end
               end
            end
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clkIn or negedge resetIn) begin
      if (!resetIn) begin
         state_q  <= IDLE;
         op_q     <= '0;
         rd_q     <= '0;
         cnt_q    <= '0;
         prod_q   <= '0;
         opnd_q   <= '0;
         neg_q    <= 1'b0;
         result_q <= '0;
         rd_out_q <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         rd_q     <= rd_d;
         cnt_q    <= cnt_d;
         prod_q   <= prod_d;
         opnd_q   <= opnd_d;
         neg_q    <= neg_d;
         result_q <= result_d;
         rd_out_q <= rd_out_d;
      end
   end

   assign busyOut   = (state_q == CALC);
   assign doneOut   = (state_q == DONE);
   assign stallOut  = (state_q == CALC) | (startIn & (state_q != CALC) & ~special_in);
   assign resultOut = result_q;
   assign rdOut     = rd_out_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed RV32M cases, latency, flush, reset and
// randomized operations compared against an arithmetic reference model.
module tb_ex_muldiv_unit;

   logic        clkIn, resetIn, startIn, flushIn;
   logic [2:0]  funct3In;
   logic [31:0] rs1DataIn, rs2DataIn;
   logic [4:0]  rdIn;
   logic        busyOut, stallOut, doneOut;
   logic [31:0] resultOut;
   logic [4:0]  rdOut;

   int          vec_cnt  = 0;
   int          err_cnt  = 0;
   logic [31:0] last_res = '0;

   ex_muldiv_unit #(.XLEN(32), .RDW(5)) dut (
      .clkIn(clkIn), .resetIn(resetIn), .startIn(startIn), .funct3In(funct3In),
      .rs1DataIn(rs1DataIn), .rs2DataIn(rs2DataIn), .rdIn(rdIn), .flushIn(flushIn),
      .busyOut(busyOut), .stallOut(stallOut), .doneOut(doneOut),
      .resultOut(resultOut), .rdOut(rdOut)
   );

   initial clkIn = 1'b0;
   always #5 clkIn = ~clkIn;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vec_cnt++;
      assert (obs === exp) else begin
         err_cnt++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: full-width integer arithmetic straight from the RV32M definitions.
   function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
      logic [63:0] as, bs, au, bu, p;
      as = {{32{a[31]}}, a};
      bs = {{32{b[31]}}, b};
      au = {32'h0, a};
      bu = {32'h0, b};
      case (f3)
         3'd0: begin p = as * bs; return p[31:0];  end
         3'd1: begin p = as * bs; return p[63:32]; end
         3'd2: begin p = as * bu; return p[63:32]; end
         3'd3: begin p = au * bu; return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
            return $signed(a) / $signed(b);
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            return $signed(a) % $signed(b);
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b);
      return (f3[2] && b == 0) ||
             ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
   endfunction

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 5))
         0:       return 32'h0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return $urandom_range(0, 20);
         default: return $urandom;
      endcase
   endfunction

   // Issues one op at the current negedge and returns at the negedge of its DONE cycle.
   // With hold set, startIn stays high with junk operands through CALC.
   task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input bit hold);
      logic [31:0] exp_res;
      bit          spec;
      int          n;
      exp_res   = ref_model(f3, a, b);
      spec      = is_special(f3, a, b);
      funct3In  = f3;
      rs1DataIn = a;
      rs2DataIn = b;
      rdIn      = rd;
      startIn   = 1'b1;
      #1 check("stall_at_issue", 64'(stallOut), 64'(!spec));
      @(posedge clkIn);
      @(negedge clkIn);
      n = 1;
      if (hold && !spec) begin
         funct3In  = 3'($urandom);
         rs1DataIn = $urandom;
         rs2DataIn = $urandom;
         rdIn      = 5'($urandom);
      end else begin
         startIn = 1'b0;
      end
      while (!doneOut && n < 40) begin
         if (n == 5) begin
            check("busy_in_calc", 64'(busyOut), 64'(1));
            check("stall_in_calc", 64'(stallOut), 64'(1));
         end
         if (n == 32) startIn = 1'b0;
         @(posedge clkIn);
         @(negedge clkIn);
         n++;
      end
      startIn = 1'b0;
      #1;
      check("latency", 64'(n), spec ? 64'(1) : 64'(33));
      check("done_pulse", 64'(doneOut), 64'(1));
      check("result", 64'(resultOut), 64'(exp_res));
      check("rd_out", 64'(rdOut), 64'(rd));
      check("stall_in_done", 64'(stallOut), 64'(0));
      last_res = exp_res;
   endtask

   initial begin
      int  seen_done;
      resetIn   = 1'b0;
      startIn   = 1'b0;
      flushIn   = 1'b0;
      funct3In  = '0;
      rs1DataIn = '0;
      rs2DataIn = '0;
      rdIn      = '0;
      repeat (2) @(negedge clkIn);
      check("rst_busy", 64'(busyOut), 64'(0));
      check("rst_done", 64'(doneOut), 64'(0));
      check("rst_stall", 64'(stallOut), 64'(0));
      check("rst_result", 64'(resultOut), 64'(0));
      check("rst_rd", 64'(rdOut), 64'(0));
      resetIn = 1'b1;
      @(negedge clkIn);

      // Directed arithmetic cases
      run_op(3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 5'd9, 1'b0);
      check("mul_7_m3", 64'(resultOut), 64'h0000_0000_FFFF_FFEB);
      @(negedge clkIn);
      check("done_drops", 64'(doneOut), 64'(0));
      check("result_held", 64'(resultOut), 64'h0000_0000_FFFF_FFEB);
      check("rd_held", 64'(rdOut), 64'(9));
      run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 1'b0);
      run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 1'b0);
      run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 1'b0);
      run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, 1'b0);
      run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd5, 1'b0);
      run_op(3'd5, 32'd100, 32'd7, 5'd6, 1'b0);
      run_op(3'd7, 32'd100, 32'd7, 5'd7, 1'b0);
      @(negedge clkIn);

      // Special cases, issued back-to-back
      run_op(3'd4, 32'd42, 32'd0, 5'd10, 1'b0);
      run_op(3'd6, 32'd5, 32'd0, 5'd11, 1'b0);
      run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 1'b0);
      run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 1'b0);
      @(negedge clkIn);

      // Back-to-back normal ops, first with startIn held through CALC
      run_op(3'd0, 32'd1234, 32'd5678, 5'd14, 1'b1);
      run_op(3'd5, 32'hDEAD_BEEF, 32'd3, 5'd15, 1'b0);
      @(negedge clkIn);

      // Flush mid-CALC: IDLE next edge, no done pulse, result untouched
      funct3In  = 3'd0;
      rs1DataIn = 32'd3;
      rs2DataIn = 32'd3;
      rdIn      = 5'd20;
      startIn   = 1'b1;
      @(negedge clkIn);
      startIn = 1'b0;
      repeat (9) @(negedge clkIn);
      flushIn = 1'b1;
      @(negedge clkIn);
      flushIn = 1'b0;
      #1;
      check("flush_busy", 64'(busyOut), 64'(0));
      check("flush_stall", 64'(stallOut), 64'(0));
      check("flush_result", 64'(resultOut), 64'(last_res));
      seen_done = 0;
      repeat (40) begin
         @(negedge clkIn);
         if (doneOut) seen_done++;
      end
      check("flush_no_done", 64'(seen_done), 64'(0));

      // Flush together with start: request dropped
      startIn = 1'b1;
      flushIn = 1'b1;
      @(negedge clkIn);
      startIn = 1'b0;
      flushIn = 1'b0;
      #1 check("flush_start_busy", 64'(busyOut), 64'(0));
      check("flush_start_done", 64'(doneOut), 64'(0));
      @(negedge clkIn);

      // Async reset mid-CALC
      funct3In  = 3'd4;
      rs1DataIn = 32'd1000;
      rs2DataIn = 32'd7;
      rdIn      = 5'd21;
      startIn   = 1'b1;
      @(negedge clkIn);
      startIn = 1'b0;
      repeat (8) @(negedge clkIn);
      #2 resetIn = 1'b0;
      #1;
      check("amid_busy", 64'(busyOut), 64'(0));
      check("amid_result", 64'(resultOut), 64'(0));
      check("amid_rd", 64'(rdOut), 64'(0));
      @(negedge clkIn);
      resetIn   = 1'b1;
      seen_done = 0;
      repeat (40) begin
         @(negedge clkIn);
         if (doneOut) seen_done++;
      end
      check("reset_no_done", 64'(seen_done), 64'(0));

      // Randomized operations against the reference model
      for (int i = 0; i < 30; i++) begin
         run_op(3'($urandom), pick_operand(), pick_operand(), 5'($urandom), 1'($urandom));
         if ($urandom_range(0, 1) == 0) @(negedge clkIn);
      end
      @(negedge clkIn);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
